// File: rtl/ascon_p_serial_ctrl.sv
// Sequencer that streams a 5-slice Ascon state through an external serial round unit.
// Optional ASCON_P_CTRL_CYCLE_CNT_EN adds a saturating busy-cycle counter on perf_cycles.
module ascon_p_serial_ctrl #(
  parameter int BW = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5*BW-1:0] state_in,
  input  logic [3:0]      nrounds,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5*BW-1:0] state_out,
  output logic            busy,
  output logic            core_en,
  output logic [2:0]      core_slice_idx,
  output logic [3:0]      core_round,
  output logic [BW-1:0]   core_slice_in,
  input  logic [BW-1:0]   core_slice_out
`ifdef ASCON_P_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]     perf_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, PRIME, READ, DONE} state_t;

  state_t        state;
  logic [BW-1:0] file [5];
  logic [2:0]    cnt;
  logic [3:0]    first_round;
  logic          accept;

  assign accept      = (state == IDLE) && in_valid && in_ready;
  // More than 12 requested rounds saturates to the full p12.
  assign first_round = (nrounds > 4'd12) ? 4'd0 : (4'd12 - nrounds);

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_out
      assign state_out[5*BW-1-gi*BW -: BW] = file[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      in_ready       <= 1'b1;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      core_en        <= 1'b0;
      core_slice_idx <= 3'd0;
      core_round     <= 4'd0;
      core_slice_in  <= '0;
      cnt            <= 3'd0;
      for (int i = 0; i < 5; i++) file[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < 5; i++) file[i] <= state_in[5*BW-1-i*BW -: BW];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            cnt      <= 3'd0;
            if (nrounds == 4'd0) begin
              state <= DONE;
            end else begin
              state          <= LOAD;
              core_en        <= 1'b1;
              core_slice_idx <= 3'd0;
              core_slice_in  <= state_in[5*BW-1 -: BW];
              core_round     <= first_round;
            end
          end
        end
        LOAD: begin
          if (core_slice_idx == 3'd4) begin
            state          <= PRIME;
            core_en        <= 1'b0;
            core_slice_idx <= 3'd0;
            core_slice_in  <= '0;
          end else begin
            core_slice_idx <= core_slice_idx + 3'd1;
            core_slice_in  <= file[core_slice_idx + 3'd1];
          end
        end
        PRIME: begin
          state          <= READ;
          core_slice_idx <= 3'd1;
          cnt            <= 3'd0;
        end
        READ: begin
          // slice_out lags slice_idx by one cycle, so slice cnt arrives now.
          file[cnt] <= core_slice_out;
          if (cnt == 3'd4) begin
            cnt            <= 3'd0;
            core_slice_idx <= 3'd0;
            if (core_round == 4'd11) begin
              state     <= DONE;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state         <= LOAD;
              core_round    <= core_round + 4'd1;
              core_en       <= 1'b1;
              core_slice_in <= file[0];
            end
          end else begin
            cnt            <= cnt + 3'd1;
            core_slice_idx <= (cnt >= 3'd3) ? 3'd4 : (cnt + 3'd2);
          end
        end
        DONE: begin
          // A zero-round job lands here with out_valid still low for one cycle.
          if (!out_valid) begin
            out_valid <= 1'b1;
            busy      <= 1'b0;
          end else if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ASCON_P_CTRL_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_cycles <= 16'd0;
    end else if (accept) begin
      perf_cycles <= 16'd0;
    end else if (busy && (perf_cycles != 16'hFFFF)) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ascon_p_serial_ctrl.md
ASCON_P_SERIAL_CTRL -- requirements
Module: ascon_p_serial_ctrl

Interface
REQ-001 Parameter BW, default 64, slice width in bits; the state is 5*BW bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  a new state and round count are offered.
REQ-005 in_ready  output  1  controller accepts; high only in IDLE.
REQ-006 state_in  input  5*BW  permutation input; x0 = [5*BW-1 -: BW], x4 = [BW-1:0].
REQ-007 nrounds  input  4  number of rounds to apply, sampled on accept.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer takes the result.
REQ-010 state_out  output  5*BW  permutation result, same slice order as state_in.
REQ-011 busy  output  1  high from the accept edge until out_valid is asserted.
REQ-012 core_en  output  1  drives the serial round unit's en (slice load strobe).
REQ-013 core_slice_idx  output  3  drives the serial round unit's slice_idx.
REQ-014 core_round  output  4  drives the serial round unit's round (constant index 0..11).
REQ-015 core_slice_in  output  BW  drives the serial round unit's slice_in.
REQ-016 core_slice_out  input  BW  registered slice_out of the round unit; 1-cycle latency after slice_idx.

Function
REQ-017 The controller SHALL hold a 5 x BW state register file; the handshake fires when in_valid && in_ready, and on that edge it loads the file from state_in and latches nrounds.
REQ-018 Effective rounds n = nrounds if 1..12, 12 if nrounds > 12; the first round index is 12-n and the index increments to 11.
REQ-019 FSM states: IDLE, LOAD, PRIME, READ, DONE.
REQ-020 LOAD: 5 cycles with core_en=1, core_slice_idx=0..4 and core_slice_in=file[idx]; core_round equals the current round index throughout LOAD, PRIME and READ.
REQ-021 PRIME: 1 cycle with core_en=0 and core_slice_idx=0.
REQ-022 READ: 5 cycles with core_en=0 and core_slice_idx=1,2,3,4,4; on each of these edges the controller SHALL write core_slice_out into file[0..4] respectively.
REQ-023 After READ: if the round index is 11, go to DONE; otherwise increment the round index and go to LOAD.
REQ-024 Each round takes exactly 11 cycles, and out_valid rises exactly 11*n cycles after the accept edge.
REQ-025 nrounds=0: IDLE goes directly to DONE with state_out = state_in; out_valid rises 1 cycle after accept, and core_en stays 0.
REQ-026 DONE: out_valid=1 and state_out = file, both stable until out_ready; the out_valid && out_ready edge returns the FSM to IDLE.
REQ-027 in_ready=0 in DONE, even if out_ready and in_valid are high together, so the next accept occurs no earlier than the cycle after the drain.
REQ-028 Changes to in_valid, state_in or nrounds while busy SHALL be ignored.
REQ-029 core_en SHALL be 0 in every state except LOAD.

Reset
REQ-030 While rstn=0: FSM=IDLE; in_ready=1 after release; out_valid=0, busy=0, core_en=0, core_slice_idx=0, core_round=0, core_slice_in=0, state_out=0, file=0.
REQ-031 Reset asserted mid-operation SHALL abort immediately with no out_valid pulse; the first accept after release SHALL start a clean sequence.

Configuration
REQ-032 Macro ASCON_P_CTRL_CYCLE_CNT_EN defined: add output perf_cycles [15:0], cleared on accept, incremented every busy cycle (saturating at 16'hFFFF), and held while in DONE/IDLE.
REQ-033 Macro undefined: no perf_cycles port and no counter logic; all other behaviour is identical.

Verification
REQ-034 All-zero state_in, nrounds=12 -> out_valid exactly 132 cycles after accept; state_out equals the software Ascon p12 of zero; core_round sequence is 0..11.
REQ-035 Random state_in, nrounds=6 -> core_round sequence is 6..11, latency 66 cycles, state_out equals the p6 model; perf_cycles=66 when the macro is enabled.
REQ-036 nrounds=0 with state_in=0x0123..cdef pattern -> out_valid 1 cycle after accept, state_out identical, core_en never asserted.
REQ-037 out_ready held low 20 cycles after out_valid -> state_out and out_valid stable, in_ready=0; in_valid and out_ready high together -> next accept occurs one cycle after the drain.
REQ-038 rstn pulsed low at cycle 40 of a 12-round run -> all outputs zero immediately, no out_valid; a new 8-round job then completes in 88 cycles with the correct result.
REQ-039 nrounds=15 -> behaves as 12 (core_round starts at 0, latency 132).
